// File: rtl/pipeline_skid_reg.sv
// Registered valid/ready stage with a skid register so in_ready never depends combinationally on out_ready.
// Latency 1 cycle from an empty stage; sustains one beat per cycle; holds up to two beats under backpressure.
module pipeline_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  // Encoding equals the number of held beats, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          case ({in_valid, out_ready})
            2'b11: main_q <= in_data;
            2'b10: begin
              state  <= FULL;
              skid_q <= in_data;
            end
            2'b01: state <= EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          // in_ready is low here, so in_data is not looked at.
          if (out_ready) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Bench for pipeline_skid_reg: WIDTH=8 and WIDTH=1 instances share control, checked against a queue model.
module tb_pipeline_skid_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       flush;
  logic [7:0] din;

  logic       in_ready8, out_valid8, in_ready1, out_valid1;
  logic [7:0] out_data8;
  logic [0:0] out_data1;
  logic [1:0] occ8, occ1;

  int checks = 0;
  int passed = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  pipeline_skid_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(din),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .flush(flush), .occupancy(occ8)
  );

  pipeline_skid_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(din[0]),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .flush(flush), .occupancy(occ1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare both DUTs against the queue model, then advance one clock and update the model.
  task automatic step();
    logic in_fire, out_fire;
    logic [7:0] head;
    @(negedge clk);
    check("occ8", {30'd0, occ8}, q.size());
    check("occ1", {30'd0, occ1}, q.size());
    check("out_valid8", {31'd0, out_valid8}, {31'd0, q.size() != 0});
    check("in_ready8", {31'd0, in_ready8}, {31'd0, q.size() < 2});
    check("in_ready1", {31'd0, in_ready1}, {31'd0, q.size() < 2});
    if (q.size() != 0) begin
      head = q[0];
      check("out_data8", {24'd0, out_data8}, {24'd0, head});
      check("out_data1", {31'd0, out_data1}, {31'd0, head[0]});
    end
    in_fire  = in_valid && (q.size() < 2);
    out_fire = out_ready && (q.size() != 0);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(din);
    end
    #1;
  endtask

  typedef struct {
    logic       vld;
    logic       rdy;
    logic       fl;
    logic [7:0] dat;
    logic [1:0] e_occ;
    logic       e_ovld;
    logic       e_irdy;
    logic [7:0] e_out;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1, 1, 0, 8'h11, 2'd1, 1, 1, 8'h11};
    tbl[1]  = '{1, 1, 0, 8'h22, 2'd1, 1, 1, 8'h22};
    tbl[2]  = '{1, 1, 0, 8'h33, 2'd1, 1, 1, 8'h33};
    tbl[3]  = '{0, 1, 0, 8'h00, 2'd0, 0, 1, 8'h33};
    tbl[4]  = '{1, 0, 0, 8'h0A, 2'd1, 1, 1, 8'h0A};
    tbl[5]  = '{1, 0, 0, 8'h0B, 2'd2, 1, 0, 8'h0A};
    tbl[6]  = '{1, 0, 0, 8'h0C, 2'd2, 1, 0, 8'h0A};
    tbl[7]  = '{1, 1, 0, 8'h0C, 2'd1, 1, 1, 8'h0B};
    tbl[8]  = '{1, 1, 0, 8'h0C, 2'd1, 1, 1, 8'h0C};
    tbl[9]  = '{0, 1, 0, 8'h00, 2'd0, 0, 1, 8'h0C};
    tbl[10] = '{1, 0, 0, 8'h01, 2'd1, 1, 1, 8'h01};
    tbl[11] = '{1, 0, 0, 8'h02, 2'd2, 1, 0, 8'h01};
    tbl[12] = '{1, 0, 1, 8'h03, 2'd0, 0, 1, 8'h00};
    tbl[13] = '{0, 1, 0, 8'h00, 2'd0, 0, 1, 8'h00};
    tbl[14] = '{1, 0, 0, 8'h44, 2'd1, 1, 1, 8'h44};
    tbl[15] = '{1, 1, 1, 8'h55, 2'd0, 0, 1, 8'h00};
    tbl[16] = '{0, 1, 0, 8'h00, 2'd0, 0, 1, 8'h00};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; din = 8'h00;
    #3;
    check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready8}, 32'd1);
    check("rst_occ", {30'd0, occ8}, 32'd0);
    check("rst_out_data", {24'd0, out_data8}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      in_valid = tbl[i].vld; out_ready = tbl[i].rdy; flush = tbl[i].fl; din = tbl[i].dat;
      step();
      check($sformatf("tbl%0d_occ", i), {30'd0, occ8}, {30'd0, tbl[i].e_occ});
      check($sformatf("tbl%0d_ovld", i), {31'd0, out_valid8}, {31'd0, tbl[i].e_ovld});
      check($sformatf("tbl%0d_irdy", i), {31'd0, in_ready8}, {31'd0, tbl[i].e_irdy});
      check($sformatf("tbl%0d_out", i), {24'd0, out_data8}, {24'd0, tbl[i].e_out});
    end

    // Hold a single beat under backpressure for ten cycles.
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; din = 8'h5A;
    step();
    in_valid = 1'b0; din = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stable_data", {24'd0, out_data8}, 32'h5A);
      check("stable_occ", {30'd0, occ8}, 32'd1);
    end
    out_ready = 1'b1;
    step();

    // Asynchronous reset mid-cycle while full.
    in_valid = 1'b1; out_ready = 1'b0; din = 8'h81;
    step();
    din = 8'h82;
    step();
    check("pre_rst_occ", {30'd0, occ8}, 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("arst_occ", {30'd0, occ8}, 32'd0);
    check("arst_out_data", {24'd0, out_data8}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready8}, 32'd1);
    check("arst_occ1", {30'd0, occ1}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; din = 8'h9C;
    step();
    check("post_rst_data", {24'd0, out_data8}, 32'h9C);

    // Random traffic with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      flush     = ($urandom_range(63, 0) == 0);
      din       = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
